// File: rtl/demod_pkg.sv
// Shared types and constants for the phase-difference demodulator scheduler.
package demod_pkg;

  localparam int unsigned ANGLE_W = 16;
  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned CH_ID_W = $clog2(MAX_CH);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } fsm_state_t;

  typedef logic [CH_ID_W-1:0] chan_id_t;

  typedef struct packed {
    logic             tlast;
    chan_id_t         ch;
    logic [ANGLE_W-1:0] diff;
  } out_beat_t;

  // Round-robin successor of channel c among n channels.
  function automatic chan_id_t next_ch(chan_id_t c, int unsigned n);
    return ((32'(c) + 32'd1) >= n) ? '0 : c + chan_id_t'(1);
  endfunction

endpackage

// File: rtl/demod_scheduler_if.sv
// Per-channel AXI-stream inputs and the single merged AXI-stream output.
interface demod_scheduler_if #(
  parameter int unsigned NUM_CH                 = 4,
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32
);
  localparam int unsigned TUSER_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]                        s00_axis_tvalid;
  logic [NUM_CH*C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata;
  logic [NUM_CH-1:0]                        s00_axis_tlast;
  logic [NUM_CH-1:0]                        s00_axis_tready;

  logic                              m00_axis_tready;
  logic                              m00_axis_tvalid;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata;
  logic                              m00_axis_tlast;
  logic [TUSER_W-1:0]                m00_axis_tuser;

  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast, m00_axis_tready,
    output s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tuser
  );

  modport master (
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast, m00_axis_tready,
    input  s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tuser
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, with wrap.
module rr_arbiter
  import demod_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  chan_id_t          ptr,
  output logic [NUM_CH-1:0] grant,
  output chan_id_t          grant_idx,
  output logic              grant_vld
);

  // Distance of channel i from the pointer, going upward with wrap.
  function automatic int rot_dist(int i, chan_id_t p);
    int d;
    d = i - int'(p);
    if (d < 0) d = d + int'(NUM_CH);
    return d;
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!grant_vld && req[i] && (rot_dist(i, ptr) == k)) begin
          grant_vld = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = chan_id_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/demod_scheduler.sv
// Round-robin scheduler sharing one phase-difference datapath across NUM_CH angle streams.
// Optional per-channel beat counters are built when DEMOD_SCHED_STATS_EN is defined.
module demod_scheduler
  import demod_pkg::*;
#(
  parameter int unsigned NUM_CH                 = 4,
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned PACKET_MODE            = 0
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  input  logic [NUM_CH-1:0]    ch_en,
  demod_scheduler_if.slave     bus,
  output logic [NUM_CH*32-1:0] stat_count
);

  localparam int unsigned SW      = C_S00_AXIS_TDATA_WIDTH;
  localparam int unsigned TUSER_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  fsm_state_t state_q, state_d;
  chan_id_t   hold_q, hold_d;
  chan_id_t   ptr_q;

  out_beat_t  out_q;
  logic       out_valid_q;

  logic [ANGLE_W-1:0] prev_q [NUM_CH];
  logic [NUM_CH-1:0]  primed_q;

  logic [NUM_CH-1:0]  req_c;
  logic [NUM_CH-1:0]  grant;
  chan_id_t           grant_idx;
  logic               grant_vld;
  logic               adv_c;
  logic               xfer_c;

  logic [ANGLE_W-1:0] sel_angle_c;
  logic [ANGLE_W-1:0] sel_prev_c;
  logic [ANGLE_W-1:0] sel_diff_c;
  logic               sel_primed_c;
  logic               sel_last_c;
  logic               held_en_c;

  // Candidates: enabled and valid; in HOLD only the held channel may compete.
  always_comb begin
    req_c = ch_en & bus.s00_axis_tvalid;
    if (state_q == HOLD) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (chan_id_t'(i) != hold_q) req_c[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req       (req_c),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign adv_c               = bus.m00_axis_tready | ~out_valid_q;
  assign xfer_c              = adv_c & grant_vld & ~s00_axis_areset;
  assign bus.s00_axis_tready = (adv_c && !s00_axis_areset) ? grant : '0;

  // Mux out the granted channel's beat and its history.
  always_comb begin
    sel_angle_c  = '0;
    sel_prev_c   = '0;
    sel_primed_c = 1'b0;
    sel_last_c   = 1'b0;
    held_en_c    = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (chan_id_t'(i) == grant_idx) begin
        sel_angle_c  = bus.s00_axis_tdata[i*SW + SW - 1 -: ANGLE_W];
        sel_prev_c   = prev_q[i];
        sel_primed_c = primed_q[i];
        sel_last_c   = bus.s00_axis_tlast[i];
      end
      if (chan_id_t'(i) == hold_q) held_en_c = ch_en[i];
    end
  end

  // Modulo-2^16 subtraction maps directly onto -pi..pi.
  assign sel_diff_c = sel_primed_c ? (sel_angle_c - sel_prev_c) : '0;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ARB: begin
        if (xfer_c && (PACKET_MODE != 0) && !sel_last_c) begin
          state_d = HOLD;
          hold_d  = grant_idx;
        end
      end
      HOLD: begin
        if (!held_en_c || (xfer_c && sel_last_c)) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q <= ARB;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) prev_q[i] <= '0;
    end else begin
      if (xfer_c) begin
        ptr_q       <= next_ch(grant_idx, NUM_CH);
        out_q.tlast <= sel_last_c;
        out_q.ch    <= grant_idx;
        out_q.diff  <= sel_diff_c;
        out_valid_q <= 1'b1;
      end else if (bus.m00_axis_tready) begin
        out_valid_q <= 1'b0;
      end
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!ch_en[i]) begin
          primed_q[i] <= 1'b0;
        end else if (xfer_c && grant[i]) begin
          primed_q[i] <= 1'b1;
          prev_q[i]   <= sel_angle_c;
        end
      end
    end
  end

  assign bus.m00_axis_tvalid = out_valid_q;
  assign bus.m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(out_q.diff);
  assign bus.m00_axis_tlast  = out_q.tlast;
  assign bus.m00_axis_tuser  = out_q.ch[TUSER_W-1:0];

`ifdef DEMOD_SCHED_STATS_EN
  logic [31:0] cnt_q [NUM_CH];

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (xfer_c && grant[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < int'(NUM_CH); i++) stat_count[i*32 +: 32] = cnt_q[i];
  end
`else
  assign stat_count = '0;
`endif

  // Low tdata bits and spare channel-id bits carry no information here.
  logic unused_bits;
  always_comb begin
    unused_bits = ^out_q.ch;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      unused_bits = unused_bits ^ (^bus.s00_axis_tdata[i*SW +: SW - ANGLE_W]);
    end
  end

endmodule

// File: tb/tb_demod_scheduler.sv
// Directed table-driven bench for demod_scheduler (arbitrate-per-beat and packet-hold builds).
module tb_demod_scheduler;
  import demod_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   en0, en1;
  logic [N*32-1:0] st0, st1;

  demod_scheduler_if #(.NUM_CH(N), .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32)) if0 ();
  demod_scheduler_if #(.NUM_CH(N), .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32)) if1 ();

  demod_scheduler #(.NUM_CH(N), .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32),
                    .PACKET_MODE(0)) dut0 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .ch_en           (en0),
    .bus             (if0),
    .stat_count      (st0)
  );

  demod_scheduler #(.NUM_CH(N), .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32),
                    .PACKET_MODE(1)) dut1 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .ch_en           (en1),
    .bus             (if1),
    .stat_count      (st1)
  );

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  tv;
    logic [3:0]  tl;
    logic [63:0] ang;   // {a3,a2,a1,a0}
    logic        mr;
    logic [3:0]  rdy;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  ou;
    logic        ol;
  } vec_t;

  vec_t v0[$];
  vec_t v1[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic [3:0] en, logic [3:0] tv, logic [3:0] tl, logic [63:0] ang,
                              logic mr, logic [3:0] rdy, logic ov, logic [15:0] od,
                              logic [1:0] ou, logic ol);
    vec_t v;
    v.en = en; v.tv = tv; v.tl = tl; v.ang = ang; v.mr = mr;
    v.rdy = rdy; v.ov = ov; v.od = od; v.ou = ou; v.ol = ol;
    return v;
  endfunction

  // Angle in the top half, junk in the low half that must be ignored.
  function automatic logic [127:0] pack_ang(logic [63:0] a);
    logic [127:0] t;
    for (int i = 0; i < 4; i++) begin
      t[i*32 +: 16]      = 16'hA5C3;
      t[i*32 + 16 +: 16] = a[i*16 +: 16];
    end
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int d, input int idx);
    logic [3:0]  rdy;
    logic        mv, ml;
    logic [31:0] md;
    logic [1:0]  mu;
    @(negedge clk);
    if (d == 0) begin
      en0 = v.en; if0.s00_axis_tvalid = v.tv; if0.s00_axis_tlast = v.tl;
      if0.s00_axis_tdata = pack_ang(v.ang); if0.m00_axis_tready = v.mr;
    end else begin
      en1 = v.en; if1.s00_axis_tvalid = v.tv; if1.s00_axis_tlast = v.tl;
      if1.s00_axis_tdata = pack_ang(v.ang); if1.m00_axis_tready = v.mr;
    end
    #1;
    rdy = (d == 0) ? if0.s00_axis_tready : if1.s00_axis_tready;
    chk($sformatf("dut%0d row%0d s_tready", d, idx), 64'(rdy), 64'(v.rdy));
    @(posedge clk);
    #1;
    mv = (d == 0) ? if0.m00_axis_tvalid : if1.m00_axis_tvalid;
    md = (d == 0) ? if0.m00_axis_tdata  : if1.m00_axis_tdata;
    mu = (d == 0) ? if0.m00_axis_tuser  : if1.m00_axis_tuser;
    ml = (d == 0) ? if0.m00_axis_tlast  : if1.m00_axis_tlast;
    chk($sformatf("dut%0d row%0d m_tvalid", d, idx), 64'(mv), 64'(v.ov));
    if (v.ov) begin
      chk($sformatf("dut%0d row%0d m_tdata", d, idx), 64'(md), 64'({16'h0, v.od}));
      chk($sformatf("dut%0d row%0d m_tuser", d, idx), 64'(mu), 64'(v.ou));
      chk($sformatf("dut%0d row%0d m_tlast", d, idx), 64'(ml), 64'(v.ol));
    end
  endtask

  logic [127:0] exp_cnt;
  logic [31:0]  exp_c;

  initial begin
    // Arbitrate-per-beat build.
    v0.push_back(mk(4'hF, 4'h1, 4'h0, 64'h0000_0000_0000_1000, 1, 4'h1, 1, 16'h0000, 0, 0));
    v0.push_back(mk(4'hF, 4'h1, 4'h0, 64'h0000_0000_0000_3000, 1, 4'h1, 1, 16'h2000, 0, 0));
    v0.push_back(mk(4'hF, 4'h0, 4'h0, 64'h0000_0000_0000_3000, 1, 4'h0, 0, 16'h0000, 0, 0));
    v0.push_back(mk(4'hF, 4'h2, 4'h0, 64'h0000_0000_7F00_3000, 1, 4'h2, 1, 16'h0000, 1, 0));
    v0.push_back(mk(4'hF, 4'h2, 4'h0, 64'h0000_0000_8100_3000, 1, 4'h2, 1, 16'h0200, 1, 0));
    v0.push_back(mk(4'hF, 4'hF, 4'h0, 64'hFF00_0500_8100_3100, 1, 4'h4, 1, 16'h0000, 2, 0));
    v0.push_back(mk(4'hF, 4'hF, 4'h0, 64'hFF00_0500_8100_3100, 1, 4'h8, 1, 16'h0000, 3, 0));
    v0.push_back(mk(4'hF, 4'hF, 4'h0, 64'hFF00_0500_8100_3100, 1, 4'h1, 1, 16'h0100, 0, 0));
    v0.push_back(mk(4'hF, 4'hF, 4'h0, 64'hFF00_0500_8100_3100, 1, 4'h2, 1, 16'h0000, 1, 0));
    v0.push_back(mk(4'hF, 4'hF, 4'h0, 64'hFF00_0400_8100_3100, 1, 4'h4, 1, 16'hFF00, 2, 0));
    for (int i = 0; i < 3; i++)
      v0.push_back(mk(4'hF, 4'hF, 4'h0, 64'hFF00_0400_8100_3100, 0, 4'h0, 1, 16'hFF00, 2, 0));
    v0.push_back(mk(4'hF, 4'hF, 4'h0, 64'hFF00_0400_8100_3100, 1, 4'h8, 1, 16'h0000, 3, 0));
    v0.push_back(mk(4'hF, 4'h1, 4'h1, 64'hFF00_0400_8100_3200, 1, 4'h1, 1, 16'h0100, 0, 1));
    v0.push_back(mk(4'hD, 4'h2, 4'h0, 64'hFF00_0400_1234_3200, 1, 4'h0, 0, 16'h0000, 0, 0));
    v0.push_back(mk(4'hF, 4'h2, 4'h0, 64'hFF00_0400_4000_3200, 1, 4'h2, 1, 16'h0000, 1, 0));
    v0.push_back(mk(4'hF, 4'h2, 4'h0, 64'hFF00_0400_4100_3200, 1, 4'h2, 1, 16'h0100, 1, 0));
    v0.push_back(mk(4'hF, 4'h0, 4'h0, 64'hFF00_0400_4100_3200, 0, 4'h0, 1, 16'h0100, 1, 0));
    v0.push_back(mk(4'hF, 4'h4, 4'h0, 64'hFF00_0400_4100_3200, 0, 4'h0, 1, 16'h0100, 1, 0));
    v0.push_back(mk(4'hF, 4'h0, 4'h0, 64'hFF00_0400_4100_3200, 1, 4'h0, 0, 16'h0000, 0, 0));
    v0.push_back(mk(4'hF, 4'h4, 4'h0, 64'hFF00_0400_4100_3200, 0, 4'h4, 1, 16'h0000, 2, 0));

    // Packet-hold build.
    v1.push_back(mk(4'hF, 4'h2, 4'h2, 64'h0000_0000_1000_0000, 1, 4'h2, 1, 16'h0000, 1, 1));
    v1.push_back(mk(4'hF, 4'hD, 4'h0, 64'h3000_2000_1000_0100, 1, 4'h4, 1, 16'h0000, 2, 0));
    v1.push_back(mk(4'hF, 4'hD, 4'h0, 64'h3000_2100_1000_0100, 1, 4'h4, 1, 16'h0100, 2, 0));
    v1.push_back(mk(4'hF, 4'hD, 4'h4, 64'h3000_2300_1000_0100, 1, 4'h4, 1, 16'h0200, 2, 1));
    v1.push_back(mk(4'hF, 4'h9, 4'h9, 64'h3000_2300_1000_0100, 1, 4'h8, 1, 16'h0000, 3, 1));
    v1.push_back(mk(4'hF, 4'h1, 4'h1, 64'h3000_2300_1000_0100, 1, 4'h1, 1, 16'h0000, 0, 1));
    v1.push_back(mk(4'hF, 4'h4, 4'h0, 64'h3000_2400_1000_0100, 1, 4'h4, 1, 16'h0100, 2, 0));
    v1.push_back(mk(4'hB, 4'h5, 4'h1, 64'h3000_2400_1000_0100, 1, 4'h0, 0, 16'h0000, 0, 0));
    v1.push_back(mk(4'hF, 4'h5, 4'h1, 64'h3000_2400_1000_0100, 1, 4'h1, 1, 16'h0000, 0, 1));
    v1.push_back(mk(4'hF, 4'h4, 4'h0, 64'h3000_2500_1000_0100, 1, 4'h4, 1, 16'h0000, 2, 0));

    // Reset with everything requesting: no ready, cleared outputs.
    rst = 1'b1;
    en0 = '1; en1 = '1;
    if0.s00_axis_tvalid = '1; if0.s00_axis_tlast = '0; if0.m00_axis_tready = 1'b1;
    if1.s00_axis_tvalid = '1; if1.s00_axis_tlast = '0; if1.m00_axis_tready = 1'b1;
    if0.s00_axis_tdata = pack_ang(64'h1111_2222_3333_4444);
    if1.s00_axis_tdata = pack_ang(64'h1111_2222_3333_4444);
    #1;
    chk("reset dut0 s_tready", 64'(if0.s00_axis_tready), 64'h0);
    chk("reset dut1 s_tready", 64'(if1.s00_axis_tready), 64'h0);
    @(posedge clk);
    #1;
    chk("reset dut0 m_tvalid", 64'(if0.m00_axis_tvalid), 64'h0);
    chk("reset dut0 m_tdata",  64'(if0.m00_axis_tdata),  64'h0);
    chk("reset dut0 m_tuser",  64'(if0.m00_axis_tuser),  64'h0);
    chk("reset dut0 m_tlast",  64'(if0.m00_axis_tlast),  64'h0);
    chk("reset dut1 m_tvalid", 64'(if1.m00_axis_tvalid), 64'h0);
    chk("reset dut0 stat",     64'(st0[63:0]),           64'h0);
    rst = 1'b0;
    if0.s00_axis_tvalid = '0;
    if1.s00_axis_tvalid = '0;

    foreach (v0[i]) apply(v0[i], 0, i);

`ifdef DEMOD_SCHED_STATS_EN
    exp_cnt = {32'd2, 32'd3, 32'd5, 32'd4};
`else
    exp_cnt = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      exp_c = exp_cnt[i*32 +: 32];
      chk($sformatf("stat ch%0d", i), 64'(st0[i*32 +: 32]), 64'(exp_c));
    end

    foreach (v1[i]) apply(v1[i], 1, i);

    // Reset in the middle of a held packet must drop HOLD.
    @(negedge clk);
    rst = 1'b1;
    if1.s00_axis_tvalid = 4'h5;
    #1;
    chk("midreset dut1 s_tready", 64'(if1.s00_axis_tready), 64'h0);
    @(posedge clk);
    #1;
    chk("midreset dut1 m_tvalid", 64'(if1.m00_axis_tvalid), 64'h0);
    chk("midreset dut0 stat ch1", 64'(st0[63:32]), 64'h0);
    rst = 1'b0;
    if1.s00_axis_tvalid = '0;
    apply(mk(4'hF, 4'h1, 4'h1, 64'h0000_0000_0000_0200, 1, 4'h1, 1, 16'h0000, 0, 1), 1, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
